// File: rtl/aes_job_scheduler.sv
// Single-job scheduler in front of a fixed-latency AES datapath: arbitrates two requesters,
// holds the key, times the datapath latency and presents each result until acknowledged.
module aes_job_scheduler #(
  parameter int unsigned N       = 128,
  parameter int unsigned LATENCY = 11
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_key_load,
  input  logic [N-1:0] i_key_in,
  input  logic         i_req0_valid,
  input  logic [N-1:0] i_req0_data,
  output logic         o_req0_ready,
  input  logic         i_req1_valid,
  input  logic [N-1:0] i_req1_data,
  output logic         o_req1_ready,
  output logic [N-1:0] o_core_pt,
  output logic [N-1:0] o_core_key,
  input  logic [N-1:0] i_core_ct,
  output logic         o_rsp_valid,
  input  logic         i_rsp_ready,
  output logic         o_rsp_id,
  output logic [N-1:0] o_rsp_data,
  output logic         o_busy,
  output logic         o_key_ok
);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StWait = 2'd1,
    StResp = 2'd2
  } state_e;

  localparam logic [7:0] LastCount = 8'(LATENCY - 1);

  state_e       r_state;
  logic [7:0]   r_count;
  logic         r_last_grant;
  logic         r_key_ok;
  logic         r_rsp_valid;
  logic         r_rsp_id;
  logic [N-1:0] r_core_pt;
  logic [N-1:0] r_core_key;
  logic [N-1:0] r_rsp_data;

  logic w_grant_en;
  logic w_pick0;
  logic w_pick1;

  // A key_load cycle takes priority over granting.
  assign w_grant_en = (r_state == StIdle) && r_key_ok && !i_key_load;
  // On a tie the requester that was not granted last wins.
  assign w_pick1    = i_req1_valid && (!i_req0_valid || !r_last_grant);
  assign w_pick0    = i_req0_valid && !w_pick1;

  assign o_req0_ready = w_grant_en && w_pick0;
  assign o_req1_ready = w_grant_en && w_pick1;

  assign o_core_pt   = r_core_pt;
  assign o_core_key  = r_core_key;
  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_id    = r_rsp_id;
  assign o_rsp_data  = r_rsp_data;
  assign o_busy      = (r_state != StIdle);
  assign o_key_ok    = r_key_ok;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= StIdle;
      r_count      <= 8'd0;
      r_last_grant <= 1'b1;
      r_key_ok     <= 1'b0;
      r_rsp_valid  <= 1'b0;
      r_rsp_id     <= 1'b0;
      r_core_pt    <= '0;
      r_core_key   <= '0;
      r_rsp_data   <= '0;
    end else begin
      case (r_state)
        StIdle: begin
          if (i_key_load) begin
            r_core_key <= i_key_in;
            r_key_ok   <= 1'b1;
          end else if (o_req0_ready || o_req1_ready) begin
            r_core_pt    <= o_req1_ready ? i_req1_data : i_req0_data;
            r_rsp_id     <= o_req1_ready;
            r_last_grant <= o_req1_ready;
            r_count      <= 8'd0;
            r_state      <= StWait;
          end
        end
        StWait: begin
          r_count <= r_count + 8'd1;
          // Capture lands LATENCY edges after the accept edge.
          if (r_count == LastCount) begin
            r_rsp_data  <= i_core_ct;
            r_rsp_valid <= 1'b1;
            r_state     <= StResp;
          end
        end
        StResp: begin
          if (i_rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= StIdle;
          end
        end
        default: begin
          r_rsp_valid <= 1'b0;
          r_state     <= StIdle;
        end
      endcase
    end
  end

endmodule
